// File: rtl/acc_pkg.sv
// acc_pkg: shared width default and strobe-priority encoding for the accumulator
package acc_pkg;
  localparam int ACC_WIDTH = 9;
  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SHIFT, OP_HOLD} op_e;
endpackage

// File: rtl/acc_if.sv
// acc_if: operand, strobes and result bus between multiplier controller and accumulator
interface acc_if
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) ();
  logic [WIDTH-1:0] entrada;
  logic load;
  logic ad;
  logic sh;
  logic [WIDTH-1:0] saida;
  modport master(output entrada, load, ad, sh, input saida);
  modport slave(input entrada, load, ad, sh, output saida);
endinterface

// File: rtl/acc_adder.sv
// acc_adder: unsigned ripple-carry adder built from a generated full-adder chain
module acc_adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/acc.sv
// acc: shift-and-add multiplier accumulator with prioritized load/add/shift-right
module acc
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input logic   clk,
  input logic   rst_n,
  acc_if.slave  bus
);
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_next;
  logic             w_unused_cout;
  op_e              w_op;
  acc_adder #(.WIDTH(WIDTH)) u_add (
    .i_a   (r_acc),
    .i_b   (bus.entrada),
    .o_sum (w_sum),
    .o_cout(w_unused_cout)
  );
  always_comb begin
    w_op   = bus.load ? OP_LOAD : bus.ad ? OP_ADD : bus.sh ? OP_SHIFT : OP_HOLD;
    w_next = w_op == OP_LOAD  ? bus.entrada :
             w_op == OP_ADD   ? w_sum :
             w_op == OP_SHIFT ? {1'b0, r_acc[WIDTH-1:1]} : r_acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_acc <= '0;
    else r_acc <= w_next;
  assign bus.saida = r_acc;
endmodule

// File: tb/tb_acc.sv
// tb_acc: table-driven, hand-sequenced and randomized checks of the accumulator
module tb_acc;
  localparam int W = 9;
  typedef struct {
    logic         load;
    logic         ad;
    logic         sh;
    logic [W-1:0] e;
    logic [W-1:0] exp;
    string        name;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  int model;
  acc_if #(.WIDTH(W)) bus ();
  acc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: saida=0x%03h expected=0x%03h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic l, input logic a, input logic s, input logic [W-1:0] e);
    bus.load = l;
    bus.ad = a;
    bus.sh = s;
    bus.entrada = e;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t v(input logic l, input logic a, input logic s, input int e, input int exp, input string n);
    vec_t r;
    r.load = l; r.ad = a; r.sh = s;
    r.e = W'(e); r.exp = W'(exp); r.name = n;
    return r;
  endfunction
  initial begin
    drive(0, 0, 0, '0);
    vecs.push_back(v(0, 0, 0, 0, 0, "idle_after_reset"));
    vecs.push_back(v(1, 0, 0, 'h15D, 'h15D, "load"));
    vecs.push_back(v(0, 1, 0, 'h15D, 'h0BA, "add_wrap"));
    vecs.push_back(v(0, 0, 1, 0, 'h05D, "shift"));
    vecs.push_back(v(1, 0, 0, 5, 5, "load5"));
    vecs.push_back(v(1, 1, 1, 3, 3, "prio_load"));
    vecs.push_back(v(0, 1, 1, 3, 6, "prio_add_over_sh"));
    vecs.push_back(v(1, 0, 0, 'h1FF, 'h1FF, "load_ones"));
    for (int i = 0; i < 3; i++) vecs.push_back(v(0, 0, 0, 'h0AB, 'h1FF, "hold"));
    for (int i = 1; i <= 9; i++) vecs.push_back(v(0, 0, 1, 0, 'h1FF >> i, "shift_out"));
    #1 rst_n = 1'b0;
    #1 check("async_reset_no_clock", bus.saida, '0);
    @(negedge clk);
    check("reset_held", bus.saida, '0);
    rst_n = 1'b1;
    foreach (vecs[k]) begin
      drive(vecs[k].load, vecs[k].ad, vecs[k].sh, vecs[k].e);
      step();
      check(vecs[k].name, bus.saida, vecs[k].exp);
    end
    drive(1, 0, 0, 'h0AA);
    step();
    check("load_aa", bus.saida, 'h0AA);
    drive(0, 0, 0, '0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid", bus.saida, '0);
    rst_n = 1'b1;
    drive(0, 1, 0, 7);
    step();
    check("add_after_reset", bus.saida, 7);
    model = 7;
    for (int i = 0; i < 400; i++) begin
      logic l, a, s;
      logic [W-1:0] e;
      l = ($urandom_range(0, 5) == 0);
      a = 1'($urandom);
      s = 1'($urandom);
      e = W'($urandom);
      drive(l, a, s, e);
      if (l) model = int'(e);
      else if (a) model = (model + int'(e)) % (1 << W);
      else if (s) model = model / 2;
      step();
      check("random", bus.saida, W'(model));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
